// File: rtl/game_reaction_timer_pkg.sv
// Shared state encoding and width helper for the reaction-time game.
// Pure definitions: no latency, no flow control.
// No backpressure: constants only.
package game_reaction_timer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_GO      = 3'd2;
    localparam logic [2:0] ST_RESULT  = 3'd3;
    localparam logic [2:0] ST_FOUL    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    function automatic int bcd_w(input int num_digits);
        return 4 * num_digits;
    endfunction

endpackage

// File: rtl/game_reaction_timer_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 cycles after clr.
// Latency: first tick TICK_CYC cycles after clr is released; no backpressure.
module ms_tick_gen #(
    parameter int CLK_HZ = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int TICK_CYC = CLK_HZ / 1000;
    localparam int CNT_W    = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(TICK_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_reaction_timer.sv
// Reaction-time game: random pre-GO delay, BCD millisecond count, foul/timeout detection.
// Latency: outputs registered, one cycle after the causing btn_pulse/tick; no backpressure.
// Optional best-time tracking enabled by defining GAME_REACTION_BEST_EN.
module game_reaction_timer
    import game_reaction_timer_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int NUM_DIGITS   = 3,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_W       = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           btn_pulse,
    input  logic [RAND_W-1:0]              rand_in,
    output logic [bcd_w(NUM_DIGITS)-1:0]   time_bcd,
    output logic                           go_led,
    output logic                           foul,
    output logic                           timeout,
    output logic [2:0]                     state_o,
    output logic [bcd_w(NUM_DIGITS)-1:0]   best_bcd,
    output logic                           best_valid
);
    localparam int BCD_W = bcd_w(NUM_DIGITS);
    localparam int DLY_W = $clog2(MIN_DELAY_MS + (2 ** RAND_W));

    logic [2:0]       r_state;
    logic [DLY_W-1:0] r_delay;
    logic [BCD_W-1:0] r_time;

    logic             w_tick;
    logic             w_clr;
    logic             w_go_enter;
    logic [BCD_W-1:0] w_inc;
    logic [NUM_DIGITS:0] w_carry;

    // Prescaler only runs in WAIT/GO; it restarts on entry to GO so the first ms is full.
    assign w_go_enter = (r_state == ST_WAIT) && w_tick && !btn_pulse && (r_delay <= DLY_W'(1));
    assign w_clr      = !ena || ((r_state != ST_WAIT) && (r_state != ST_GO)) || w_go_enter;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bcd
            logic [3:0] w_dig;
            assign w_dig            = r_time[4*gi +: 4];
            assign w_carry[gi+1]    = w_carry[gi] && (w_dig == 4'd9);
            assign w_inc[4*gi +: 4] = !w_carry[gi]      ? w_dig :
                                      (w_dig == 4'd9)   ? 4'd0  : w_dig + 4'd1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_delay <= '0;
            r_time  <= '0;
        end else if (!ena) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (btn_pulse) begin
                        r_delay <= DLY_W'(MIN_DELAY_MS) + DLY_W'(rand_in);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (btn_pulse) begin
                        r_state <= ST_FOUL;
                        r_time  <= '0;
                    end else if (w_go_enter) begin
                        r_state <= ST_GO;
                        r_time  <= '0;
                    end else if (w_tick) begin
                        r_delay <= r_delay - DLY_W'(1);
                    end
                end
                ST_GO: begin
                    if (btn_pulse) begin
                        r_state <= ST_RESULT;
                    end else if (w_tick) begin
                        if (w_carry[NUM_DIGITS]) begin
                            r_state <= ST_TIMEOUT;
                        end else begin
                            r_time <= w_inc;
                        end
                    end
                end
                ST_RESULT, ST_FOUL, ST_TIMEOUT: begin
                    if (btn_pulse) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign time_bcd = r_time;
    assign state_o  = r_state;
    assign go_led   = (r_state == ST_GO);
    assign foul     = (r_state == ST_FOUL);
    assign timeout  = (r_state == ST_TIMEOUT);

`ifdef GAME_REACTION_BEST_EN
    logic [BCD_W-1:0] r_best;
    logic             r_best_vld;

    // Packed BCD compares correctly as plain unsigned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best     <= '0;
            r_best_vld <= 1'b0;
        end else if (ena && (r_state == ST_GO) && btn_pulse &&
                     (!r_best_vld || (r_time < r_best))) begin
            r_best     <= r_time;
            r_best_vld <= 1'b1;
        end
    end

    assign best_bcd   = r_best;
    assign best_valid = r_best_vld;
`else
    assign best_bcd   = '0;
    assign best_valid = 1'b0;
`endif

endmodule

// File: tb/tb_game_reaction_timer.sv
// Randomized and directed bench for game_reaction_timer against an integer-millisecond model.
module tb_game_reaction_timer;
    localparam int CLK_HZ   = 10_000;
    localparam int TICK     = CLK_HZ / 1000;
    localparam int NDIG     = 3;
    localparam int MIN_DLY  = 5;
    localparam int RW       = 4;
    localparam int MAX_MS   = 999;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic            btn_pulse;
    logic [RW-1:0]   rand_in;
    logic [11:0]     time_bcd;
    logic            go_led;
    logic            foul;
    logic            timeout;
    logic [2:0]      state_o;
    logic [11:0]     best_bcd;
    logic            best_valid;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: game phase per the published state numbering, times as integers.
    int m_st, m_ms, m_dly, m_phase, m_best;
    bit m_bv;

    game_reaction_timer #(
        .CLK_HZ(CLK_HZ), .NUM_DIGITS(NDIG), .MIN_DELAY_MS(MIN_DLY), .RAND_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_pulse(btn_pulse), .rand_in(rand_in),
        .time_bcd(time_bcd), .go_led(go_led), .foul(foul), .timeout(timeout),
        .state_o(state_o), .best_bcd(best_bcd), .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic logic [30:0] dut_pack();
        return {state_o, go_led, foul, timeout, time_bcd, best_valid, best_bcd};
    endfunction

    function automatic logic [30:0] model_pack();
        logic [11:0] b;
        b = m_bv ? to_bcd(m_best) : 12'h000;
        return {3'(m_st), m_st == 2, m_st == 4, m_st == 5, to_bcd(m_ms), m_bv, b};
    endfunction

    task automatic model_reset();
        m_st = 0; m_ms = 0; m_dly = 0; m_phase = 0; m_best = 0; m_bv = 0;
    endtask

    task automatic model_step();
        bit tk;
        tk = (m_phase % TICK) == (TICK - 1);
        if (!ena) begin
            m_st = 0;
            m_phase = 0;
        end else begin
            case (m_st)
                0: begin
                    m_phase = 0;
                    if (btn_pulse) begin
                        m_dly = MIN_DLY + int'(rand_in);
                        m_st  = 1;
                    end
                end
                1: begin
                    if (btn_pulse) begin
                        m_st = 4; m_ms = 0; m_phase++;
                    end else if (tk && m_dly <= 1) begin
                        m_st = 2; m_ms = 0; m_phase = 0;
                    end else begin
                        if (tk) m_dly--;
                        m_phase++;
                    end
                end
                2: begin
                    if (btn_pulse) begin
                        m_st = 3;
`ifdef GAME_REACTION_BEST_EN
                        if (!m_bv || m_ms < m_best) begin
                            m_best = m_ms; m_bv = 1;
                        end
`endif
                    end else begin
                        if (tk) begin
                            if (m_ms == MAX_MS) m_st = 5;
                            else m_ms++;
                        end
                        m_phase++;
                    end
                end
                default: begin
                    m_phase = 0;
                    if (btn_pulse) m_st = 0;
                end
            endcase
        end
    endtask

    task automatic step(input logic b);
        btn_pulse = b;
        @(posedge clk);
        model_step();
        #1;
        btn_pulse = 1'b0;
        chk("cycle_outputs", 64'(dut_pack()), 64'(model_pack()));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic start_game(input int r);
        rand_in = RW'(r);
        step(1'b1);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; btn_pulse = 1'b0; rand_in = '0;
        model_reset();
        #2;
        chk("reset_state", 64'(dut_pack()), 64'd0);
        #10 rst_n = 1'b1;

        // Normal game: delay 8 ms, result 123 ms.
        start_game(3);
        idle_steps(79);
        chk("normal_pre_go", 64'(go_led), 64'd0);
        step(1'b0);
        chk("normal_go_led", 64'(go_led), 64'd1);
        idle_steps(123 * TICK + 5);
        step(1'b1);
        chk("normal_state", 64'(state_o), 64'd3);
        chk("normal_time", 64'(time_bcd), 64'h123);
        chk("normal_go_off", 64'(go_led), 64'd0);
        step(1'b1);

        // False start.
        start_game(0);
        idle_steps(19);
        step(1'b1);
        chk("foul_state", 64'(state_o), 64'd4);
        chk("foul_flag", 64'(foul), 64'd1);
        chk("foul_time", 64'(time_bcd), 64'h000);
        step(1'b1);
        chk("foul_to_idle", 64'(state_o), 64'd0);

        // Press coincides with the final WAIT tick.
        start_game(0);
        idle_steps(MIN_DLY * TICK - 1);
        step(1'b1);
        chk("tie_wait_state", 64'(state_o), 64'd4);
        step(1'b1);

        // Press coincides with the tick that would make 050.
        start_game(0);
        idle_steps(MIN_DLY * TICK);
        chk("tie_go_entered", 64'(state_o), 64'd2);
        idle_steps(50 * TICK - 1);
        step(1'b1);
        chk("tie_go_state", 64'(state_o), 64'd3);
        chk("tie_go_time", 64'(time_bcd), 64'h049);
        step(1'b1);

        // Timeout after 1000 ticks.
        start_game(0);
        idle_steps(MIN_DLY * TICK);
        idle_steps((MAX_MS + 1) * TICK - 1);
        chk("timeout_pre", 64'(state_o), 64'd2);
        step(1'b0);
        chk("timeout_state", 64'(state_o), 64'd5);
        chk("timeout_time", 64'(time_bcd), 64'h999);
        chk("timeout_flag", 64'(timeout), 64'd1);
        step(1'b1);

        // ena drop in GO.
        start_game(0);
        idle_steps(MIN_DLY * TICK + 3 * TICK + 5);
        ena = 1'b0;
        step(1'b1);
        chk("ena_abort_state", 64'(state_o), 64'd0);
        chk("ena_abort_time", 64'(time_bcd), 64'h003);
        ena = 1'b1;
        step(1'b0);

        // Asynchronous reset in WAIT.
        start_game(7);
        idle_steps(20);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset", 64'(dut_pack()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Best time: 200, 150, then a foul.
        start_game(0);
        idle_steps(MIN_DLY * TICK + 200 * TICK + 5);
        step(1'b1);
        chk("best_r1", 64'(time_bcd), 64'h200);
        step(1'b1);
        start_game(0);
        idle_steps(MIN_DLY * TICK + 150 * TICK + 5);
        step(1'b1);
        chk("best_r2", 64'(time_bcd), 64'h150);
        step(1'b1);
        start_game(0);
        idle_steps(10);
        step(1'b1);
`ifdef GAME_REACTION_BEST_EN
        chk("best_bcd", 64'(best_bcd), 64'h150);
        chk("best_valid", 64'(best_valid), 64'd1);
`else
        chk("best_bcd", 64'(best_bcd), 64'h000);
        chk("best_valid", 64'(best_valid), 64'd0);
`endif
        step(1'b1);

        // Random play.
        for (int i = 0; i < 20000; i++) begin
            ena     = ($urandom_range(0, 999) != 0);
            rand_in = RW'($urandom);
            step($urandom_range(0, 149) == 0);
        end
        ena = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/game_reaction_timer.md
Name: game_reaction_timer

Overview:
Parametrised reaction-time game for the seven-segment games top level. The game waits a random delay, then lights "GO" and counts elapsed milliseconds in BCD until the player presses the button. It detects false starts (press before GO) and timeouts (counter saturation). It consumes the single-cycle press from the existing button pulse chain and a random value from the random digit source, and outputs BCD digits to the seven-segment driver path.

Parameters:
CLK_HZ, 10_000_000, system clock frequency; millisecond tick period TICK_CYC = CLK_HZ/1000 (must be >= 2).
NUM_DIGITS, 3, BCD digits in the time display; maximum reaction time is 10^NUM_DIGITS - 1 ms.
MIN_DELAY_MS, 1000, fixed part of the pre-GO delay in ms.
RAND_W, 10, width of the random extra delay in ms (0 .. 2^RAND_W - 1).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  game selected; low forces IDLE
btn_pulse  in  1  one-cycle press pulse, already synchronised and debounced
rand_in  in  RAND_W  random value, sampled only on game start
time_bcd  out  4*NUM_DIGITS  displayed time, digit 0 in LSBs
go_led  out  1  high in GO state only
foul  out  1  high in FOUL state
timeout  out  1  high in TIMEOUT state
state_o  out  3  current FSM state encoding
best_bcd  out  4*NUM_DIGITS  best time (optional feature)
best_valid  out  1  best_bcd holds a valid result (optional feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE, time_bcd=0, go_led=0, foul=0, timeout=0, delay counter=0, prescaler=0, best_bcd=0, best_valid=0. Reset mid-game aborts immediately with no partial update.
- States (state_o): IDLE=0, WAIT=1, GO=2, RESULT=3, FOUL=4, TIMEOUT=5; values 6 and 7 recover to IDLE on the next cycle.
- IDLE: time_bcd holds the last result; reset value is 0. A btn_pulse loads delay = MIN_DELAY_MS + rand_in (unsigned, width sized to hold the maximum), clears the prescaler, and moves to WAIT.
- WAIT: the prescaler emits a tick every TICK_CYC cycles; each tick decrements delay.
  - Tick with delay==1 and no btn_pulse: go to GO, clear time_bcd, clear the prescaler. go_led rises the cycle after that tick.
  - btn_pulse in any WAIT cycle, including the final-tick cycle, goes to FOUL. The button has priority over the tick.
- GO: each tick increments time_bcd as a BCD ripple (digit 9 to 0 with carry).
  - btn_pulse goes to RESULT with time_bcd frozen. If a tick and a press occur in the same cycle, the press wins and the increment is dropped.
  - A tick while time_bcd is all 9s goes to TIMEOUT; time_bcd stays all 9s.
- RESULT, FOUL, TIMEOUT: hold outputs. btn_pulse goes to IDLE. FOUL shows time_bcd=0.
- ena=0: next cycle state=IDLE, prescaler cleared, time_bcd retained; btn_pulse is ignored while ena=0.
- All outputs are registered or decoded from registered state; there is no combinational path from btn_pulse to any output.

Optional Feature:
GAME_REACTION_BEST_EN:
- Defined: on entry to RESULT, if best_valid==0 or time_bcd < best_bcd, best_bcd <= time_bcd and best_valid <= 1. The compare is unsigned on the packed BCD value, which is order-preserving. FOUL and TIMEOUT never update the best. Best is cleared only by reset.
- Undefined: best_bcd=0 and best_valid=0 constantly; no registers are inferred.

Decomposition:
- Shared package/header holds the state encoding constants (ST_IDLE..ST_TIMEOUT) and a BCD_W localparam helper (4*NUM_DIGITS).
- One sub-module: ms_tick_gen (CLK_HZ param; clk, rst_n, clr, tick). It emits a one-cycle tick every TICK_CYC cycles after clr.
- The BCD counter is a generate loop inside game_reaction_timer.

Test Plan (CLK_HZ=10_000, so TICK_CYC=10; MIN_DELAY_MS=5; NUM_DIGITS=3; RAND_W=4):
- Normal game: rand_in=3, press, wait 80 cycles, go_led=1; press after 123 ticks -> state RESULT, time_bcd=0x123, go_led=0.
- False start: rand_in=0, press, press again 20 cycles later -> state FOUL, foul=1, time_bcd=0; a further press -> IDLE.
- Tie, WAIT: press on the exact cycle of the final WAIT tick -> FOUL, not GO.
- Tie, GO: press coincident with a tick at time_bcd=0x049 -> RESULT with 0x049, not 0x050.
- Timeout: no press in GO for 1000 ticks -> TIMEOUT, time_bcd=0x999, timeout=1.
- Abort paths:
  - ena=0 during GO -> IDLE next cycle.
  - rst_n=0 mid-WAIT -> all outputs reset asynchronously.
- Best time (GAME_REACTION_BEST_EN): results 0x200, 0x150, then FOUL -> best_bcd=0x150 and best_valid=1.
